// File: rtl/toggle_period_meter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : toggle_period_meter_pkg
// Description : State encoding and saturating arithmetic helpers for the meter.
// Revision    : 1.0
// ============================================================================
package toggle_period_meter_pkg;

    localparam int MAX_W = 32;
    typedef logic [MAX_W-1:0] word_t;

    typedef logic [1:0] state_t;
    localparam state_t SYNC = 2'd0;
    localparam state_t HIGH = 2'd1;
    localparam state_t LOW  = 2'd2;

    // All-ones value of a w-bit field, held in a MAX_W-bit word.
    function automatic word_t sat_max(input int w);
        if (w >= MAX_W) return '1;
        return (word_t'(1) << w) - word_t'(1);
    endfunction

    function automatic word_t sat_inc(input word_t v, input int w);
        word_t m;
        m = sat_max(w);
        return (v >= m) ? m : v + word_t'(1);
    endfunction

    // Sum carries one extra bit so an overflow is seen before clamping.
    function automatic word_t sat_add(input word_t a, input word_t b, input int w);
        word_t          m;
        logic [MAX_W:0] s;
        m = sat_max(w);
        s = {1'b0, a} + {1'b0, b};
        return (s > {1'b0, m}) ? m : s[MAX_W-1:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/toggle_period_meter_if.sv
`default_nettype none
// ============================================================================
// Module      : toggle_period_meter_if
// Description : Stream input and measurement outputs of the toggle period meter.
// Revision    : 1.0
// ============================================================================
interface toggle_period_meter_if #(
    parameter int CNT_W = 8
);
    logic             en;
    logic             din;
    logic [CNT_W-1:0] high_len;
    logic [CNT_W-1:0] low_len;
    logic [CNT_W-1:0] period;
    logic             meas_valid;
    logic [CNT_W-1:0] edge_cnt;
    logic             stuck;

    modport master (
        output en, din,
        input  high_len, low_len, period, meas_valid, edge_cnt, stuck
    );

    modport slave (
        input  en, din,
        output high_len, low_len, period, meas_valid, edge_cnt, stuck
    );
endinterface
`default_nettype wire

// File: rtl/toggle_period_meter_edge_det.sv
`default_nettype none
// ============================================================================
// Module      : toggle_period_meter_edge_det
// Description : Registers a synchronous input and flags its rising/falling edges.
// Revision    : 1.0
// ============================================================================
module toggle_period_meter_edge_det (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_din,
    output logic      o_rise,
    output logic      o_fall
);
    logic r_din_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_din_d <= 1'b0;
        else      r_din_d <= i_din;
    end

    assign o_rise = i_din & ~r_din_d;
    assign o_fall = ~i_din & r_din_d;
endmodule
`default_nettype wire

// File: rtl/toggle_period_meter.sv
`default_nettype none
// ============================================================================
// Module      : toggle_period_meter
// Description : Measures high/low/period of a toggle stream, counts rising edges, flags stuck input.
// Revision    : 1.0
// ============================================================================
module toggle_period_meter
    import toggle_period_meter_pkg::*;
#(
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = 200
) (
    input  wire logic             clk,
    input  wire logic             rst,
    toggle_period_meter_if.slave  bus
);
    localparam logic [CNT_W-1:0] c_TIMEOUT = CNT_W'(TIMEOUT);
    localparam bit               c_TO_EN   = (TIMEOUT != 0);

    logic w_rise, w_fall;

    toggle_period_meter_edge_det u_edge_det (
        .clk    (clk),
        .rst    (rst),
        .i_din  (bus.din),
        .o_rise (w_rise),
        .o_fall (w_fall)
    );

    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_hi, r_lo, w_hi_nxt, w_lo_nxt;
    logic [CNT_W-1:0] r_high_len, r_low_len, r_period, r_edge_cnt;
    logic [CNT_W-1:0] w_high_len_nxt, w_low_len_nxt, w_period_nxt, w_edge_cnt_nxt;
    logic             r_meas_valid, r_stuck, w_meas_valid_nxt, w_stuck_nxt;

    logic [CNT_W-1:0] w_hi_inc, w_lo_inc, w_sum;
    logic             w_hi_to, w_lo_to;

    assign w_hi_inc = CNT_W'(sat_inc(word_t'(r_hi), CNT_W));
    assign w_lo_inc = CNT_W'(sat_inc(word_t'(r_lo), CNT_W));
    assign w_sum    = CNT_W'(sat_add(word_t'(r_hi), word_t'(r_lo), CNT_W));
    assign w_hi_to  = c_TO_EN && (r_hi == c_TIMEOUT);
    assign w_lo_to  = c_TO_EN && (r_lo == c_TIMEOUT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= SYNC;
        else      r_state <= w_state_nxt;
    end

    // An edge takes priority over a timeout match in the same cycle.
    always_comb begin
        w_state_nxt = r_state;
        if (!bus.en) begin
            w_state_nxt = SYNC;
        end else begin
            case (r_state)
                SYNC:    if (w_rise) w_state_nxt = HIGH;
                HIGH:    if (w_fall) w_state_nxt = LOW;
                         else if (w_hi_to) w_state_nxt = SYNC;
                LOW:     if (w_rise) w_state_nxt = HIGH;
                         else if (w_lo_to) w_state_nxt = SYNC;
                default: w_state_nxt = SYNC;
            endcase
        end
    end

    always_comb begin
        w_hi_nxt         = r_hi;
        w_lo_nxt         = r_lo;
        w_high_len_nxt   = r_high_len;
        w_low_len_nxt    = r_low_len;
        w_period_nxt     = r_period;
        w_meas_valid_nxt = 1'b0;
        w_stuck_nxt      = r_stuck;
        w_edge_cnt_nxt   = r_edge_cnt;
        if (!bus.en) begin
            w_hi_nxt = '0;
            w_lo_nxt = '0;
        end else begin
            case (r_state)
                SYNC: begin
                    if (w_rise) begin
                        w_hi_nxt = CNT_W'(1);
                        w_lo_nxt = '0;
                    end
                end
                HIGH: begin
                    if (w_fall) begin
                        w_lo_nxt = CNT_W'(1);
                    end else if (w_hi_to) begin
                        w_hi_nxt    = '0;
                        w_lo_nxt    = '0;
                        w_stuck_nxt = 1'b1;
                    end else begin
                        w_hi_nxt = w_hi_inc;
                    end
                end
                LOW: begin
                    if (w_rise) begin
                        w_high_len_nxt   = r_hi;
                        w_low_len_nxt    = r_lo;
                        w_period_nxt     = w_sum;
                        w_meas_valid_nxt = 1'b1;
                        w_hi_nxt         = CNT_W'(1);
                        w_lo_nxt         = '0;
                    end else if (w_lo_to) begin
                        w_hi_nxt    = '0;
                        w_lo_nxt    = '0;
                        w_stuck_nxt = 1'b1;
                    end else begin
                        w_lo_nxt = w_lo_inc;
                    end
                end
                default: begin
                    w_hi_nxt = '0;
                    w_lo_nxt = '0;
                end
            endcase
            if (w_rise) begin
                w_stuck_nxt    = 1'b0;
                w_edge_cnt_nxt = r_edge_cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hi         <= '0;
            r_lo         <= '0;
            r_high_len   <= '0;
            r_low_len    <= '0;
            r_period     <= '0;
            r_meas_valid <= 1'b0;
            r_stuck      <= 1'b0;
            r_edge_cnt   <= '0;
        end else begin
            r_hi         <= w_hi_nxt;
            r_lo         <= w_lo_nxt;
            r_high_len   <= w_high_len_nxt;
            r_low_len    <= w_low_len_nxt;
            r_period     <= w_period_nxt;
            r_meas_valid <= w_meas_valid_nxt;
            r_stuck      <= w_stuck_nxt;
            r_edge_cnt   <= w_edge_cnt_nxt;
        end
    end

    assign bus.high_len   = r_high_len;
    assign bus.low_len    = r_low_len;
    assign bus.period     = r_period;
    assign bus.meas_valid = r_meas_valid;
    assign bus.edge_cnt   = r_edge_cnt;
    assign bus.stuck      = r_stuck;
endmodule
`default_nettype wire

// File: tb/tb_toggle_period_meter.sv
`default_nettype none
// ============================================================================
// Module      : tb_toggle_period_meter
// Description : Directed self-checking bench; 8-bit/TIMEOUT=200 and 4-bit/no-timeout instances.
// Revision    : 1.0
// ============================================================================
module tb_toggle_period_meter;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic en  = 1'b1;
    logic din = 1'b0;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    toggle_period_meter_if #(.CNT_W(8)) bus8 ();
    toggle_period_meter_if #(.CNT_W(4)) bus4 ();

    assign bus8.en  = en;
    assign bus8.din = din;
    assign bus4.en  = en;
    assign bus4.din = din;

    toggle_period_meter #(.CNT_W(8), .TIMEOUT(200)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
    toggle_period_meter #(.CNT_W(4), .TIMEOUT(0))   dut4 (.clk(clk), .rst(rst), .bus(bus4));

    // Drive din for one clock; outputs are then sampled 1 time unit after the edge.
    task automatic step(input logic d);
        din = d;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        din = 1'b0;
        en  = 1'b1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic test_reset();
        din = 1'b0;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({bus8.high_len, bus8.low_len, bus8.period, bus8.meas_valid, bus8.edge_cnt, bus8.stuck} !== 34'd0) begin
            bad++;
            $display("FAIL reset8 got=%h want=0", {bus8.high_len, bus8.low_len, bus8.period, bus8.meas_valid, bus8.edge_cnt, bus8.stuck});
        end
        total++;
        if ({bus4.high_len, bus4.low_len, bus4.period, bus4.meas_valid, bus4.edge_cnt, bus4.stuck} !== 18'd0) begin
            bad++;
            $display("FAIL reset4 got=%h want=0", {bus4.high_len, bus4.low_len, bus4.period, bus4.meas_valid, bus4.edge_cnt, bus4.stuck});
        end
        rst = 1'b1;
    endtask

    // Two-stage T-flip-flop chain with T=1 on the first stage; q2 has period 4.
    task automatic test_tff();
        logic q1, q2, prev;
        int   rises;
        logic exp_mv;
        apply_reset();
        q1 = 1'b0; q2 = 1'b0; prev = 1'b0; rises = 0;
        for (int i = 0; i < 18; i++) begin
            q2 = q2 ^ q1;
            q1 = ~q1;
            step(q2);
            exp_mv = q2 && !prev && (rises > 0);
            if (q2 && !prev) rises++;
            prev = q2;
            total++;
            if (bus8.meas_valid !== exp_mv) begin
                bad++;
                $display("FAIL tff_mv i=%0d got=%b want=%b", i, bus8.meas_valid, exp_mv);
            end
            total++;
            if (bus8.edge_cnt !== 8'(rises)) begin
                bad++;
                $display("FAIL tff_edge i=%0d got=%0d want=%0d", i, bus8.edge_cnt, rises);
            end
            if (exp_mv) begin
                total++;
                if ({bus8.high_len, bus8.low_len, bus8.period} !== {8'd2, 8'd2, 8'd4}) begin
                    bad++;
                    $display("FAIL tff_meas i=%0d got=%0d/%0d/%0d want=2/2/4", i, bus8.high_len, bus8.low_len, bus8.period);
                end
            end
        end
    endtask

    task automatic test_h3l5();
        logic exp_mv;
        apply_reset();
        for (int p = 0; p < 3; p++) begin
            for (int c = 0; c < 8; c++) begin
                step(c < 3);
                exp_mv = (c == 0) && (p > 0);
                total++;
                if (bus8.meas_valid !== exp_mv) begin
                    bad++;
                    $display("FAIL h3l5_mv p=%0d c=%0d got=%b want=%b", p, c, bus8.meas_valid, exp_mv);
                end
                if (exp_mv) begin
                    total++;
                    if ({bus8.high_len, bus8.low_len, bus8.period} !== {8'd3, 8'd5, 8'd8}) begin
                        bad++;
                        $display("FAIL h3l5_meas p=%0d got=%0d/%0d/%0d want=3/5/8", p, bus8.high_len, bus8.low_len, bus8.period);
                    end
                end
            end
        end
    endtask

    task automatic test_timeout();
        apply_reset();
        step(0);
        for (int k = 1; k <= 250; k++) begin
            step(1);
            total++;
            if (bus8.stuck !== (k >= 201)) begin
                bad++;
                $display("FAIL to_stuck k=%0d got=%b want=%b", k, bus8.stuck, (k >= 201));
            end
            total++;
            if (bus8.meas_valid !== 1'b0) begin
                bad++;
                $display("FAIL to_mv k=%0d got=%b want=0", k, bus8.meas_valid);
            end
        end
        total++;
        if (bus4.stuck !== 1'b0) begin
            bad++;
            $display("FAIL to_disabled got=%b want=0", bus4.stuck);
        end
        step(0);
        step(0);
        total++;
        if (bus8.stuck !== 1'b1) begin
            bad++;
            $display("FAIL to_sticky got=%b want=1", bus8.stuck);
        end
        step(1);
        total++;
        if ({bus8.stuck, bus8.meas_valid, bus8.edge_cnt} !== {1'b0, 1'b0, 8'd2}) begin
            bad++;
            $display("FAIL to_clear got stuck=%b mv=%b edge=%0d want 0/0/2", bus8.stuck, bus8.meas_valid, bus8.edge_cnt);
        end
        step(1);
        step(0);
        step(0);
        step(1);
        total++;
        if ({bus8.meas_valid, bus8.high_len, bus8.low_len, bus8.period} !== {1'b1, 8'd2, 8'd2, 8'd4}) begin
            bad++;
            $display("FAIL to_restart got mv=%b %0d/%0d/%0d want 1 2/2/4", bus8.meas_valid, bus8.high_len, bus8.low_len, bus8.period);
        end
    endtask

    task automatic test_saturate();
        apply_reset();
        repeat (20) step(1);
        repeat (3)  step(0);
        step(1);
        total++;
        if ({bus4.meas_valid, bus4.high_len, bus4.low_len, bus4.period} !== {1'b1, 4'd15, 4'd3, 4'd15}) begin
            bad++;
            $display("FAIL sat4 got mv=%b %0d/%0d/%0d want 1 15/3/15", bus4.meas_valid, bus4.high_len, bus4.low_len, bus4.period);
        end
        total++;
        if ({bus8.meas_valid, bus8.high_len, bus8.low_len, bus8.period} !== {1'b1, 8'd20, 8'd3, 8'd23}) begin
            bad++;
            $display("FAIL sat8 got mv=%b %0d/%0d/%0d want 1 20/3/23", bus8.meas_valid, bus8.high_len, bus8.low_len, bus8.period);
        end
    endtask

    task automatic test_reset_mid();
        logic [8:0] dpat;
        logic [8:0] mvpat;
        dpat  = 9'b100110011;
        mvpat = 9'b100010000;
        apply_reset();
        repeat (4) step(1);
        repeat (2) step(0);
        repeat (4) step(1);
        repeat (2) step(0);
        total++;
        if ({bus8.high_len, bus8.low_len, bus8.period, bus8.edge_cnt} !== {8'd4, 8'd2, 8'd6, 8'd2}) begin
            bad++;
            $display("FAIL rm_pre got %0d/%0d/%0d edge=%0d want 4/2/6 edge=2", bus8.high_len, bus8.low_len, bus8.period, bus8.edge_cnt);
        end
        rst = 1'b0;
        #1;
        total++;
        if ({bus8.high_len, bus8.low_len, bus8.period, bus8.meas_valid, bus8.edge_cnt, bus8.stuck} !== 34'd0) begin
            bad++;
            $display("FAIL rm_async got=%h want=0", {bus8.high_len, bus8.low_len, bus8.period, bus8.meas_valid, bus8.edge_cnt, bus8.stuck});
        end
        din = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int i = 0; i < 9; i++) begin
            step(dpat[i]);
            total++;
            if (bus8.meas_valid !== mvpat[i]) begin
                bad++;
                $display("FAIL rm_mv i=%0d got=%b want=%b", i, bus8.meas_valid, mvpat[i]);
            end
        end
        total++;
        if ({bus8.high_len, bus8.low_len, bus8.period, bus8.edge_cnt} !== {8'd2, 8'd2, 8'd4, 8'd3}) begin
            bad++;
            $display("FAIL rm_post got %0d/%0d/%0d edge=%0d want 2/2/4 edge=3", bus8.high_len, bus8.low_len, bus8.period, bus8.edge_cnt);
        end
    endtask

    task automatic test_enable();
        logic [9:0] dpat;
        dpat = 10'b1100110001;
        apply_reset();
        step(1); step(1); step(0); step(0); step(1);
        total++;
        if ({bus8.meas_valid, bus8.period, bus8.edge_cnt} !== {1'b1, 8'd4, 8'd2}) begin
            bad++;
            $display("FAIL en_pre got mv=%b per=%0d edge=%0d want 1/4/2", bus8.meas_valid, bus8.period, bus8.edge_cnt);
        end
        en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step(dpat[i]);
            total++;
            if ({bus8.meas_valid, bus8.high_len, bus8.low_len, bus8.period, bus8.edge_cnt} !== {1'b0, 8'd2, 8'd2, 8'd4, 8'd2}) begin
                bad++;
                $display("FAIL en_hold i=%0d got mv=%b %0d/%0d/%0d edge=%0d want 0 2/2/4 edge=2", i, bus8.meas_valid, bus8.high_len, bus8.low_len, bus8.period, bus8.edge_cnt);
            end
        end
        en = 1'b1;
        step(1);
        total++;
        if ({bus8.meas_valid, bus8.edge_cnt} !== {1'b0, 8'd2}) begin
            bad++;
            $display("FAIL en_nofalse got mv=%b edge=%0d want 0/2", bus8.meas_valid, bus8.edge_cnt);
        end
        step(0); step(0); step(1);
        total++;
        if ({bus8.meas_valid, bus8.edge_cnt} !== {1'b0, 8'd3}) begin
            bad++;
            $display("FAIL en_sync got mv=%b edge=%0d want 0/3", bus8.meas_valid, bus8.edge_cnt);
        end
        step(1); step(1); step(0); step(1);
        total++;
        if ({bus8.meas_valid, bus8.high_len, bus8.low_len, bus8.period, bus8.edge_cnt} !== {1'b1, 8'd3, 8'd1, 8'd4, 8'd4}) begin
            bad++;
            $display("FAIL en_restart got mv=%b %0d/%0d/%0d edge=%0d want 1 3/1/4 edge=4", bus8.meas_valid, bus8.high_len, bus8.low_len, bus8.period, bus8.edge_cnt);
        end
    endtask

    task automatic test_min_period();
        logic [4:0] mvpat;
        mvpat = 5'b10100;
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            step((i % 2) == 0);
            total++;
            if (bus8.meas_valid !== mvpat[i]) begin
                bad++;
                $display("FAIL min_mv i=%0d got=%b want=%b", i, bus8.meas_valid, mvpat[i]);
            end
            if (mvpat[i]) begin
                total++;
                if ({bus8.high_len, bus8.low_len, bus8.period} !== {8'd1, 8'd1, 8'd2}) begin
                    bad++;
                    $display("FAIL min_meas i=%0d got %0d/%0d/%0d want 1/1/2", i, bus8.high_len, bus8.low_len, bus8.period);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_tff();
        test_h3l5();
        test_timeout();
        test_saturate();
        test_reset_mid();
        test_enable();
        test_min_period();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end
endmodule
`default_nettype wire
